// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared types and constants for the key_repeat_bank input front end.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT       = 2'd1,
      REPEAT     = 2'd2,
      REPEAT_OFF = 2'd3
   } key_state_t;

   // Default timings for a 25 MHz clock: 10 ms debounce, 200 ms delay, 50 ms period.
   localparam int c_N_KEYS_DEF        = 8;
   localparam int c_DEBOUNCE_CYC_DEF  = 250000;
   localparam int c_REPEAT_DELAY_DEF  = 5000000;
   localparam int c_REPEAT_PERIOD_DEF = 1250000;
   localparam int c_CNT_W_DEF         = 23;

   localparam int KEY_LEFT     = 0;
   localparam int KEY_RIGHT    = 1;
   localparam int KEY_ROTATE   = 2;
   localparam int KEY_DROP     = 3;
   localparam int KEY_RESET    = 4;
   localparam int KEY_START    = 5;
   localparam int KEY_PAUSE    = 6;
   localparam int KEY_CONTINUE = 7;

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
// Module   : key_channel
// Purpose  : One key: 2-flop synchroniser, debouncer and hold-to-repeat FSM.
// Revision : 1.0 - initial release
// ============================================================================
module key_channel
   import key_pkg::*;
#(
   parameter int ACTIVE_LOW    = 1,
   parameter int DEBOUNCE_CYC  = c_DEBOUNCE_CYC_DEF,
   parameter int REPEAT_DELAY  = c_REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = c_REPEAT_PERIOD_DEF,
   parameter bit REPEAT_EN     = 1'b0,
   parameter int CNT_W         = c_CNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_raw_i,
   input  logic enable_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam logic             c_RELEASED = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [1:0]       sync_q;
   logic             sample;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   key_state_t       state_q, state_d;
   logic             commit, press_evt, release_evt, fire;
   logic             press_q, press_d;
   logic             release_q, release_d;

   // Normalised so that 1 always means pressed.
   assign sample = sync_q[1] ^ c_RELEASED;

   always_comb begin
      stable_d = stable_q;
      dcnt_d   = dcnt_q;
      commit   = 1'b0;
      if (sample == stable_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == c_DEB_LAST) begin
         stable_d = sample;
         dcnt_d   = '0;
         commit   = 1'b1;
      end else begin
         dcnt_d = dcnt_q + 1'b1;
      end
   end

   assign press_evt   = commit & sample;
   assign release_evt = commit & ~sample;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire    = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_evt) begin
               fire    = 1'b1;
               rcnt_d  = '0;
               state_d = REPEAT_EN ? WAIT : REPEAT_OFF;
            end
         end
         WAIT: begin
            if (rcnt_q == c_DLY_LAST) begin
               fire    = 1'b1;
               rcnt_d  = '0;
               state_d = REPEAT;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         REPEAT: begin
            if (rcnt_q == c_PER_LAST) begin
               fire   = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      // Release wins over any repeat that falls due on the same edge.
      if (release_evt) begin
         state_d = IDLE;
         rcnt_d  = '0;
         fire    = 1'b0;
      end
   end

   assign press_d   = fire & enable_i;
   assign release_d = release_evt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= {2{c_RELEASED}};
         stable_q  <= 1'b0;
         dcnt_q    <= '0;
         state_q   <= IDLE;
         rcnt_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_raw_i};
         stable_q  <= stable_d;
         dcnt_q    <= dcnt_d;
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/key_repeat_bank.sv
`default_nettype none
// ============================================================================
// Module   : key_repeat_bank
// Purpose  : N-key push-button front end with debounce and per-key auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_repeat_bank
   import key_pkg::*;
#(
   parameter int                N_KEYS        = c_N_KEYS_DEF,
   parameter int                ACTIVE_LOW    = 1,
   parameter int                DEBOUNCE_CYC  = c_DEBOUNCE_CYC_DEF,
   parameter int                REPEAT_DELAY  = c_REPEAT_DELAY_DEF,
   parameter int                REPEAT_PERIOD = c_REPEAT_PERIOD_DEF,
   parameter logic [N_KEYS-1:0] REPEAT_MASK   = N_KEYS'(8'b0000_1011),
   parameter int                CNT_W         = c_CNT_W_DEF
) (
   input  logic              CLK_25M,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] keys_raw,
   input  logic              enable,
   output logic [N_KEYS-1:0] keys_level,
   output logic [N_KEYS-1:0] keys_press,
   output logic [N_KEYS-1:0] keys_release
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_channel #(
         .ACTIVE_LOW    (ACTIVE_LOW),
         .DEBOUNCE_CYC  (DEBOUNCE_CYC),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REPEAT_EN     (REPEAT_MASK[i]),
         .CNT_W         (CNT_W)
      ) u_chan (
         .clk_i     (CLK_25M),
         .rst_i     (Reset),
         .key_raw_i (keys_raw[i]),
         .enable_i  (enable),
         .level_o   (keys_level[i]),
         .press_o   (keys_press[i]),
         .release_o (keys_release[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_repeat_bank
// Purpose  : Table-driven, scoreboarded bench for key_repeat_bank (4 keys).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_repeat_bank;

   localparam int NK = 4;

   logic          clk = 1'b0;
   logic          rst_r;
   logic [NK-1:0] raw_r;
   logic          en_r;
   logic [NK-1:0] lvl_w, prs_w, rls_w;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int            e;
      logic [NK-1:0] raw;
      logic          en;
      logic          rst;
   } stim_t;

   // Level holds from its edge onward; press/release are pulses on that edge only.
   typedef struct {
      int            e;
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rls;
   } exp_t;

   stim_t stim_tab[$];
   exp_t  exp_tab[$];
   exp_t  sb_q[$];

   always #5 clk = ~clk;

   key_repeat_bank #(
      .N_KEYS        (NK),
      .ACTIVE_LOW    (1),
      .DEBOUNCE_CYC  (4),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3),
      .REPEAT_MASK   (4'b0001),
      .CNT_W         (8)
   ) dut (
      .CLK_25M      (clk),
      .Reset        (rst_r),
      .keys_raw     (raw_r),
      .enable       (en_r),
      .keys_level   (lvl_w),
      .keys_press   (prs_w),
      .keys_release (rls_w)
   );

   task automatic add_stim(input int e, input logic [NK-1:0] raw, input logic en, input logic rst);
      stim_t s;
      s.e = e; s.raw = raw; s.en = en; s.rst = rst;
      stim_tab.push_back(s);
   endtask

   task automatic add_exp(input int e, input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                          input logic [NK-1:0] rls);
      exp_t x;
      x.e = e; x.lvl = lvl; x.prs = prs; x.rls = rls;
      exp_tab.push_back(x);
   endtask

   task automatic check_out(input string name, input int k);
      exp_t w;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s edge %0d: scoreboard empty", name, k);
         return;
      end
      w = sb_q.pop_front();
      if ({lvl_w, prs_w, rls_w} !== {w.lvl, w.prs, w.rls}) begin
         n_errors++;
         $display("FAIL %s edge %0d: got lvl=%b prs=%b rls=%b, want lvl=%b prs=%b rls=%b",
                  name, k, lvl_w, prs_w, rls_w, w.lvl, w.prs, w.rls);
      end
   endtask

   task automatic do_reset();
      exp_t z;
      z.e = 0; z.lvl = '0; z.prs = '0; z.rls = '0;
      rst_r = 1'b1; raw_r = '1; en_r = 1'b1;
      repeat (2) @(posedge clk);
      sb_q.push_back(z);
      @(negedge clk);
      check_out("reset_state", 0);
      @(posedge clk); #1;
      rst_r = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   // Edge 0 is the first posedge inside this task; inputs change 1 time unit after an edge.
   task automatic run_scen(input string name, input int len);
      exp_t          cur;
      logic [NK-1:0] lvl_now;
      lvl_now = '0;
      @(posedge clk); #1;
      for (int k = 0; k < len; k++) begin
         foreach (stim_tab[s]) begin
            if (stim_tab[s].e == k) begin
               raw_r = stim_tab[s].raw;
               en_r  = stim_tab[s].en;
               rst_r = stim_tab[s].rst;
            end
         end
         cur.e = k; cur.lvl = lvl_now; cur.prs = '0; cur.rls = '0;
         foreach (exp_tab[x]) begin
            if (exp_tab[x].e == k) begin
               cur     = exp_tab[x];
               lvl_now = exp_tab[x].lvl;
            end
         end
         sb_q.push_back(cur);
         @(negedge clk);
         check_out(name, k);
         @(posedge clk); #1;
      end
      stim_tab.delete();
      exp_tab.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_r = 1'b1; raw_r = '1; en_r = 1'b1;

      // Basic press on a non-repeating key.
      do_reset();
      add_stim(0,  4'b1101, 1'b1, 1'b0);
      add_stim(30, 4'b1111, 1'b1, 1'b0);
      add_exp(6,  4'b0010, 4'b0010, 4'b0000);
      add_exp(36, 4'b0000, 4'b0000, 4'b0010);
      run_scen("basic_press", 45);

      // Three cycles low, one high: never stable long enough to commit.
      do_reset();
      for (int p = 0; p < 10; p++) begin
         add_stim(4*p,     4'b1110, 1'b1, 1'b0);
         add_stim(4*p + 3, 4'b1111, 1'b1, 1'b0);
      end
      run_scen("bounce", 50);

      // Hold key 0: press, delay, periodic repeats, release beats the repeat at 46.
      do_reset();
      add_stim(0,  4'b1110, 1'b1, 1'b0);
      add_stim(40, 4'b1111, 1'b1, 1'b0);
      add_exp(6, 4'b0001, 4'b0001, 4'b0000);
      for (int t = 16; t <= 43; t += 3) add_exp(t, 4'b0001, 4'b0001, 4'b0000);
      add_exp(46, 4'b0000, 4'b0000, 4'b0001);
      run_scen("auto_repeat", 55);

      // Enable low across edges 15..20 drops the repeats at 16 and 19.
      do_reset();
      add_stim(0,  4'b1110, 1'b1, 1'b0);
      add_stim(14, 4'b1110, 1'b0, 1'b0);
      add_stim(20, 4'b1110, 1'b1, 1'b0);
      add_stim(40, 4'b1111, 1'b1, 1'b0);
      add_exp(6, 4'b0001, 4'b0001, 4'b0000);
      add_exp(16, 4'b0001, 4'b0000, 4'b0000);
      for (int t = 22; t <= 43; t += 3) add_exp(t, 4'b0001, 4'b0001, 4'b0000);
      add_exp(46, 4'b0000, 4'b0000, 4'b0001);
      run_scen("enable_mask", 55);

      // All four keys together; only key 0 repeats.
      do_reset();
      add_stim(0,  4'b0000, 1'b1, 1'b0);
      add_stim(30, 4'b1111, 1'b1, 1'b0);
      add_exp(6, 4'b1111, 4'b1111, 4'b0000);
      for (int t = 16; t <= 34; t += 3) add_exp(t, 4'b1111, 4'b0001, 4'b0000);
      add_exp(36, 4'b0000, 4'b0000, 4'b1111);
      run_scen("simultaneous", 45);

      // One-cycle reset at edge 19 while key 0 is held; press recommits at 25.
      do_reset();
      add_stim(0,  4'b1110, 1'b1, 1'b0);
      add_stim(18, 4'b1110, 1'b1, 1'b1);
      add_stim(19, 4'b1110, 1'b1, 1'b0);
      add_stim(40, 4'b1111, 1'b1, 1'b0);
      add_exp(6,  4'b0001, 4'b0001, 4'b0000);
      add_exp(16, 4'b0001, 4'b0001, 4'b0000);
      add_exp(19, 4'b0000, 4'b0000, 4'b0000);
      add_exp(25, 4'b0001, 4'b0001, 4'b0000);
      for (int t = 35; t <= 44; t += 3) add_exp(t, 4'b0001, 4'b0001, 4'b0000);
      add_exp(46, 4'b0000, 4'b0000, 4'b0001);
      run_scen("reset_mid_hold", 55);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
